// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - frame constants, status codes and FSM states for uart_frame_master
package uart_frame_pkg;

    localparam logic [7:0] SOF = 8'hAA;
    localparam logic [7:0] EOF = 8'hD5;

    localparam logic [3:0] OP_READ  = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_FCS     = 2'b01;
    localparam logic [1:0] STAT_HDR     = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_SOF,
        S_TX_OL,
        S_TX_ADDR,
        S_TX_DATA,
        S_TX_FCS,
        S_TX_EOF,
        S_RX_SOF,
        S_RX_OL,
        S_RX_ADDR,
        S_RX_DATA,
        S_RX_FCS,
        S_RX_EOF,
        S_DONE
    } state_t;

endpackage

// File: rtl/uart_frame_fcs.sv
// rtl/uart_frame_fcs.sv - byte-wise XOR frame check accumulator, shared by transmit and receive
module uart_frame_fcs (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] fcs
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcs <= 8'h00;
        end else if (clr) begin
            fcs <= 8'h00;
        end else if (en) begin
            fcs <= fcs ^ data;
        end
    end

endmodule

// File: rtl/uart_frame_master.sv
// rtl/uart_frame_master.sv - UART register-access frame master; UART_FRAME_MASTER_TIMEOUT_EN enables the RX byte timeout
module uart_frame_master
    import uart_frame_pkg::*;
#(
    parameter int DATA_BYTES     = 2,
    parameter int ADDR_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [8*ADDR_BYTES-1:0] cmd_addr_i,
    input  logic [3:0]              cmd_len_i,
    input  logic                    wdata_valid_i,
    output logic                    wdata_ready_o,
    input  logic [8*DATA_BYTES-1:0] wdata_i,
    output logic                    rdata_valid_o,
    output logic [8*DATA_BYTES-1:0] rdata_o,
    output logic                    rdata_last_o,
    output logic                    done_o,
    output logic [1:0]              status_o,
    output logic [7:0]              tx_data_o,
    output logic                    tx_write_o,
    input  logic                    tx_full_i,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_present_i,
    output logic                    rx_read_o
);

    localparam int DW   = 8 * DATA_BYTES;
    localparam int AW   = 8 * ADDR_BYTES;
    localparam int MAXB = (DATA_BYTES > ADDR_BYTES) ? DATA_BYTES : ADDR_BYTES;
    localparam int BC_W = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_BYTES - 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BYTES - 1);

    state_t          state;
    logic            write_q;
    logic [AW-1:0]   addr_q;
    logic [3:0]      len_q;
    logic [BC_W-1:0] bcnt;
    logic [3:0]      wcnt;
    logic [DW-1:0]   wsh;
    logic [DW-1:0]   rsh;
    logic [DW-1:0]   rsh_next;
    logic            popped_q;
    logic            hdr_err;
    logic            fcs_err;
    logic            fcs_clr;
    logic            fcs_en;
    logic [7:0]      fcs_data;
    logic [7:0]      fcs;
    logic [7:0]      ol;
    logic [AW-1:0]   addr_shifted;
    logic [7:0]      addr_byte;
    logic            in_rx;
    logic            to_hit;
    logic            last_word;

    assign cmd_ready_o  = (state == S_IDLE);
    assign ol           = {write_q ? OP_WRITE : OP_READ, len_q};
    assign addr_shifted = addr_q << {bcnt, 3'b000};
    assign addr_byte    = addr_shifted[AW-1 -: 8];
    assign rsh_next     = DW'({rsh, rx_data_i});
    assign last_word    = (wcnt == len_q);
    assign in_rx        = (state >= S_RX_SOF) && (state <= S_RX_EOF);

    // popped_q blocks a second pop so the rx buffer head can advance first
    assign rx_read_o = in_rx && rx_present_i && !popped_q && !to_hit;

`ifdef UART_FRAME_MASTER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (!in_rx || rx_read_o) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign to_hit = in_rx && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign to_hit = 1'b0;
`endif

    always_comb begin
        tx_write_o    = 1'b0;
        tx_data_o     = 8'h00;
        wdata_ready_o = 1'b0;
        case (state)
            S_TX_SOF:  begin tx_data_o = SOF;       tx_write_o = !tx_full_i; end
            S_TX_OL:   begin tx_data_o = ol;        tx_write_o = !tx_full_i; end
            S_TX_ADDR: begin tx_data_o = addr_byte; tx_write_o = !tx_full_i; end
            S_TX_DATA: begin
                if (bcnt == '0) begin
                    tx_data_o     = wdata_i[DW-1 -: 8];
                    tx_write_o    = wdata_valid_i && !tx_full_i;
                    wdata_ready_o = tx_write_o;
                end else begin
                    tx_data_o  = wsh[DW-1 -: 8];
                    tx_write_o = !tx_full_i;
                end
            end
            S_TX_FCS:  begin tx_data_o = fcs;       tx_write_o = !tx_full_i; end
            S_TX_EOF:  begin tx_data_o = EOF;       tx_write_o = !tx_full_i; end
            default:   ;
        endcase
    end

    assign fcs_clr  = (state == S_IDLE) || (state == S_TX_EOF);
    assign fcs_en   = (tx_write_o && (state inside {S_TX_OL, S_TX_ADDR, S_TX_DATA}))
                   || (rx_read_o && (state inside {S_RX_OL, S_RX_ADDR, S_RX_DATA}));
    assign fcs_data = in_rx ? rx_data_i : tx_data_o;

    uart_frame_fcs u_fcs (
        .clk  (clk),
        .rst  (rst),
        .clr  (fcs_clr),
        .en   (fcs_en),
        .data (fcs_data),
        .fcs  (fcs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            write_q       <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            bcnt          <= '0;
            wcnt          <= '0;
            wsh           <= '0;
            rsh           <= '0;
            popped_q      <= 1'b0;
            hdr_err       <= 1'b0;
            fcs_err       <= 1'b0;
            rdata_valid_o <= 1'b0;
            rdata_o       <= '0;
            rdata_last_o  <= 1'b0;
            done_o        <= 1'b0;
            status_o      <= STAT_OK;
        end else begin
            rdata_valid_o <= 1'b0;
            rdata_last_o  <= 1'b0;
            done_o        <= 1'b0;
            popped_q      <= rx_read_o;
            if (to_hit) begin
                state    <= S_DONE;
                done_o   <= 1'b1;
                status_o <= STAT_TIMEOUT;
            end else begin
                case (state)
                    S_IDLE: begin
                        status_o <= STAT_OK;
                        if (cmd_valid_i) begin
                            write_q <= cmd_write_i;
                            addr_q  <= cmd_addr_i;
                            len_q   <= cmd_len_i;
                            hdr_err <= 1'b0;
                            fcs_err <= 1'b0;
                            state   <= S_TX_SOF;
                        end
                    end
                    S_TX_SOF: if (tx_write_o) state <= S_TX_OL;
                    S_TX_OL: if (tx_write_o) begin
                        bcnt  <= '0;
                        state <= S_TX_ADDR;
                    end
                    S_TX_ADDR: if (tx_write_o) begin
                        if (bcnt == ADDR_LAST) begin
                            bcnt  <= '0;
                            wcnt  <= '0;
                            state <= write_q ? S_TX_DATA : S_TX_FCS;
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
                    S_TX_DATA: if (tx_write_o) begin
                        wsh <= (bcnt == '0) ? DW'({wdata_i, 8'h00}) : DW'({wsh, 8'h00});
                        if (bcnt == DATA_LAST) begin
                            bcnt <= '0;
                            if (last_word) state <= S_TX_FCS;
                            else           wcnt  <= wcnt + 4'd1;
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
                    S_TX_FCS: if (tx_write_o) state <= S_TX_EOF;
                    S_TX_EOF: if (tx_write_o) begin
                        bcnt <= '0;
                        wcnt <= '0;
                        if (write_q) begin
                            state    <= S_DONE;
                            done_o   <= 1'b1;
                            status_o <= STAT_OK;
                        end else begin
                            state <= S_RX_SOF;
                        end
                    end
                    S_RX_SOF: if (rx_read_o && rx_data_i == SOF) state <= S_RX_OL;
                    S_RX_OL: if (rx_read_o) begin
                        if (rx_data_i != ol) hdr_err <= 1'b1;
                        bcnt  <= '0;
                        state <= S_RX_ADDR;
                    end
                    S_RX_ADDR: if (rx_read_o) begin
                        if (rx_data_i != addr_byte) hdr_err <= 1'b1;
                        if (bcnt == ADDR_LAST) begin
                            bcnt  <= '0;
                            wcnt  <= '0;
                            state <= S_RX_DATA;
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
                    S_RX_DATA: if (rx_read_o) begin
                        rsh <= rsh_next;
                        if (bcnt == DATA_LAST) begin
                            bcnt          <= '0;
                            rdata_valid_o <= 1'b1;
                            rdata_o       <= rsh_next;
                            rdata_last_o  <= last_word;
                            if (last_word) state <= S_RX_FCS;
                            else           wcnt  <= wcnt + 4'd1;
                        end else begin
                            bcnt <= bcnt + BC_W'(1);
                        end
                    end
                    S_RX_FCS: if (rx_read_o) begin
                        if (rx_data_i != fcs) fcs_err <= 1'b1;
                        state <= S_RX_EOF;
                    end
                    S_RX_EOF: if (rx_read_o) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                        if (fcs_err)                          status_o <= STAT_FCS;
                        else if (hdr_err || rx_data_i != EOF) status_o <= STAT_HDR;
                        else                                  status_o <= STAT_OK;
                    end
                    S_DONE: begin
                        status_o <= STAT_OK;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_master.sv
// tb/tb_uart_frame_master.sv - scoreboard bench for uart_frame_master; timeout case runs with UART_FRAME_MASTER_TIMEOUT_EN
module tb_uart_frame_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [15:0] cmd_addr_i;
    logic [3:0]  cmd_len_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [15:0] wdata_i;
    logic        rdata_valid_o, rdata_last_o, done_o;
    logic [15:0] rdata_o;
    logic [1:0]  status_o;
    logic [7:0]  tx_data_o;
    logic        tx_write_o, tx_full_i;
    logic [7:0]  rx_data_i;
    logic        rx_present_i, rx_read_o;

    uart_frame_master #(.DATA_BYTES(2), .ADDR_BYTES(2), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
        .done_o(done_o), .status_o(status_o),
        .tx_data_o(tx_data_o), .tx_write_o(tx_write_o), .tx_full_i(tx_full_i),
        .rx_data_i(rx_data_i), .rx_present_i(rx_present_i), .rx_read_o(rx_read_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  exp_tx[$];
    logic [16:0] exp_rd[$];
    logic [1:0]  exp_st[$];
    logic [7:0]  rx_q[$];
    logic [15:0] w_q[$];

    int ncmp = 0, nfail = 0;
    int cyc = 0, tx_cnt = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, d_base = 0;
    int stall_viol = 0, last_tx_cyc = 0, done_cyc = 0, t0 = 0;
    bit pop_rx = 1'b0, pop_w = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        ncmp++;
        nfail++;
        $display("FAIL %s: got %0h, expected no output", name, act);
    endtask

    // monitor: pops scoreboard queues whenever the DUT presents an output
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (tx_write_o) begin
                tx_cnt++;
                last_tx_cyc = cyc;
                if (tx_full_i) stall_viol++;
                if (exp_tx.size() == 0) unexpected("tx_byte", 32'(tx_data_o));
                else check("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
            end
            if (wdata_ready_o) begin wr_cnt++; pop_w = 1'b1; end
            if (rx_read_o)     begin rd_cnt++; pop_rx = 1'b1; end
            if (rdata_valid_o) begin
                if (exp_rd.size() == 0) unexpected("rdata", 32'({rdata_last_o, rdata_o}));
                else check("rdata_last_word", 32'({rdata_last_o, rdata_o}), 32'(exp_rd.pop_front()));
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_st.size() == 0) unexpected("done_status", 32'(status_o));
                else check("done_status", 32'(status_o), 32'(exp_st.pop_front()));
            end
        end
    end

    // rx buffer and write-word source models
    always @(posedge clk) begin
        #1;
        if (pop_rx && rx_q.size() != 0) rx_q.delete(0);
        if (pop_w && w_q.size() != 0) w_q.delete(0);
        pop_rx = 1'b0;
        pop_w  = 1'b0;
        rx_present_i  = (rx_q.size() != 0);
        rx_data_i     = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        wdata_valid_i = (w_q.size() != 0);
        wdata_i       = (w_q.size() != 0) ? w_q[0] : 16'h0000;
    end

    task automatic start_cmd(input logic wr, input logic [15:0] addr, input logic [3:0] len);
        d_base = done_cnt;
        wr_cnt = 0;
        rd_cnt = 0;
        @(posedge clk); #1;
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic finish_cmd(input string name);
        int n;
        n = 0;
        while (done_cnt == d_base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(done_cnt - d_base), 32'd1);
        @(negedge clk);
        check({name, "_txq_left"}, 32'(exp_tx.size()), 32'd0);
        check({name, "_rdq_left"}, 32'(exp_rd.size()), 32'd0);
        check({name, "_stq_left"}, 32'(exp_st.size()), 32'd0);
        check({name, "_rxq_left"}, 32'(rx_q.size()), 32'd0);
        exp_tx.delete();
        exp_rd.delete();
        exp_st.delete();
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        tx_full_i = 1'b0; wdata_valid_i = 1'b0; wdata_i = '0; rx_data_i = '0; rx_present_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_tx_write", 32'(tx_write_o), 32'd0);
        check("rst_rx_read", 32'(rx_read_o), 32'd0);
        check("rst_outputs", 32'({wdata_ready_o, rdata_valid_o, rdata_last_o, done_o, status_o, rdata_o}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        exp_tx = {8'hAA, 8'h11, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h56, 8'h78, 8'h7F, 8'hD5};
        w_q    = {16'hABCD, 16'h5678};
        exp_st.push_back(2'b00);
        start_cmd(1'b1, 16'h1234, 4'd1);
        finish_cmd("wr1");
        check("wr1_wready_pulses", 32'(wr_cnt), 32'd2);

        exp_tx = {8'hAA, 8'h00, 8'h00, 8'h10, 8'h10, 8'hD5};
        rx_q   = {8'h55, 8'hAA, 8'h00, 8'h00, 8'h10, 8'hBE, 8'hEF, 8'h41, 8'hD5};
        exp_rd.push_back({1'b1, 16'hBEEF});
        exp_st.push_back(2'b00);
        start_cmd(1'b0, 16'h0010, 4'd0);
        finish_cmd("rd_ok");
        check("rd_ok_rx_pops", 32'(rd_cnt), 32'd9);

        exp_tx = {8'hAA, 8'h00, 8'h00, 8'h10, 8'h10, 8'hD5};
        rx_q   = {8'hAA, 8'h00, 8'h00, 8'h10, 8'hBE, 8'hEF, 8'h42, 8'hD5};
        exp_rd.push_back({1'b1, 16'hBEEF});
        exp_st.push_back(2'b01);
        start_cmd(1'b0, 16'h0010, 4'd0);
        finish_cmd("rd_fcs");

        exp_tx = {8'hAA, 8'h00, 8'h00, 8'h10, 8'h10, 8'hD5};
        rx_q   = {8'hAA, 8'h00, 8'h00, 8'h11, 8'hBE, 8'hEF, 8'h40, 8'hD4};
        exp_rd.push_back({1'b1, 16'hBEEF});
        exp_st.push_back(2'b10);
        start_cmd(1'b0, 16'h0010, 4'd0);
        finish_cmd("rd_hdr");

        exp_tx = {8'hAA, 8'h01, 8'h20, 8'h00, 8'h21, 8'hD5};
        rx_q   = {8'hAA, 8'h01, 8'h20, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h29, 8'hD5};
        exp_rd.push_back({1'b0, 16'h1234});
        exp_rd.push_back({1'b1, 16'h5678});
        exp_st.push_back(2'b00);
        start_cmd(1'b0, 16'h2000, 4'd1);
        finish_cmd("rd_burst");
        check("rd_burst_rx_pops", 32'(rd_cnt), 32'd10);

        exp_tx = {8'hAA, 8'h12, 8'h01, 8'h02, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'hA5, 8'hA5, 8'hEE, 8'hD5};
        w_q    = {16'h0F00, 16'h00F0, 16'hA5A5};
        exp_st.push_back(2'b00);
        stall_viol = 0;
        start_cmd(1'b1, 16'h0102, 4'd2);
        repeat (3) @(posedge clk);
        #1;
        tx_full_i = 1'b1;
        t0 = tx_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("full_hold_writes", 32'(tx_cnt - t0), 32'd0);
        tx_full_i = 1'b0;
        finish_cmd("wr_full");
        check("wr_full_viol", 32'(stall_viol), 32'd0);
        check("wr_full_wready_pulses", 32'(wr_cnt), 32'd3);

`ifdef UART_FRAME_MASTER_TIMEOUT_EN
        exp_tx = {8'hAA, 8'h00, 8'h00, 8'h40, 8'h40, 8'hD5};
        exp_st.push_back(2'b11);
        start_cmd(1'b0, 16'h0040, 4'd0);
        finish_cmd("timeout");
        check("timeout_latency", 32'(done_cyc - last_tx_cyc), 32'd51);
        check("timeout_rx_pops", 32'(rd_cnt), 32'd0);
`endif

        exp_tx = {8'hAA, 8'h11, 8'h00, 8'h00, 8'h12, 8'h34};
        w_q    = {16'h1234};
        start_cmd(1'b1, 16'h0000, 4'd1);
        repeat (20) @(negedge clk);
        check("mid_txq_left", 32'(exp_tx.size()), 32'd0);
        check("mid_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("mid_wready_pulses", 32'(wr_cnt), 32'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("arst_outputs", 32'({tx_write_o, wdata_ready_o, rx_read_o, rdata_valid_o, done_o, status_o}), 32'd0);
        w_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("arst_no_done", 32'(done_cnt - d_base), 32'd0);
        check("arst_idle_ready", 32'(cmd_ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
